sd_bus_arbiter: RTL and testbench
=================================

SD_BUS_ARBITER -- requirements
Module: sd_bus_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 8: idle cycles with sd_cs=1, sd_mosi=1 between consecutive transfers; legal range 1..255.
REQ-002 Parameter BUSY_TIMEOUT, default 24'hFFFFFF: maximum cycles a granted engine may hold busy; legal range 16..2^24-1.
REQ-003 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port init_done, input, 1: SD init engine finished; level.
REQ-006 Ports init_cs and init_mosi, input, 1 each: SPI lines driven by the init engine.
REQ-007 Ports rd_req and wr_req, input, 1 each: user block-read and block-write requests; level.
REQ-008 Ports rd_addr and wr_addr, input, 32 each: user block addresses.
REQ-009 Ports rd_ack and wr_ack, output, 1 each: one-cycle request-accepted pulses.
REQ-010 Ports rd_done and wr_done, output, 1 each: one-cycle transfer-complete pulses.
REQ-011 Port timeout_err, output, 1: one-cycle pulse when a transfer is aborted by timeout.
REQ-012 Ports read_start and write_start, output, 1 each: engine start pulses.
REQ-013 Ports read_address and write_address, output, 32 each: latched engine addresses.
REQ-014 Ports read_busy and write_busy, input, 1 each: engine busy flags.
REQ-015 Ports read_cs, read_mosi, write_cs, write_mosi, input, 1 each: engine SPI lines.
REQ-016 Ports sd_cs and sd_mosi, output, 1 each: muxed SPI lines to the card.
REQ-017 Port grant, output, 2: 2'b00 init/none, 2'b01 read, 2'b10 write.

Function
REQ-018 States: INIT, IDLE, RD_START, RD_BUSY, WR_START, WR_BUSY, GAP.
REQ-019 INIT: grant=00, sd_cs=init_cs, sd_mosi=init_mosi; init_done=1 -> GAP.
REQ-020 IDLE and GAP: sd_cs=1, sd_mosi=1, grant=00.
REQ-021 GAP: counter runs 0..GAP_CYCLES-1, then -> IDLE; the counter clears on entry.
REQ-022 IDLE, only rd_req=1 -> RD_START; only wr_req=1 -> WR_START.
REQ-023 IDLE, both requests set: round-robin; the direction not granted last wins; after reset, read wins first.
REQ-024 On IDLE -> RD_START: rd_ack=1 for one cycle, rd_addr latched into read_address; write side symmetric.
REQ-025 RD_START: read_start=1 for exactly one cycle, grant=01, sd_cs/sd_mosi follow read_cs/read_mosi; -> RD_BUSY next cycle.
REQ-026 RD_BUSY: mux held on the read engine; read_busy falling (1 -> 0 seen after at least one busy=1 cycle) -> rd_done pulse, last_grant=read, -> GAP.
REQ-027 WR_START and WR_BUSY: behave as REQ-025 and REQ-026, with write signals, grant=10, and wr_done.
REQ-028 Timeout counter, 24 bit: clears on entry to *_START; increments in *_BUSY; reaching BUSY_TIMEOUT -> timeout_err pulse, no done pulse, last_grant updated, -> GAP.
REQ-029 Timeout also covers busy never rising.
REQ-030 Requests arriving outside IDLE are held pending, not dropped; no ack until IDLE.
REQ-031 init_done falling in any state -> INIT next cycle: active transfer abandoned, no done or err pulse, mux switches to init lines.
REQ-032 read_address and write_address change only on their ack cycle.
REQ-033 Only one of read_start or write_start is ever high; grant is one-hot or zero.
REQ-034 All outputs are registered except sd_cs, sd_mosi, and grant, which are combinational from state and the selected engine lines.

Reset
REQ-035 rst=1 at a clock edge -> INIT, grant=00, last_grant=write (so read wins first), counters=0.
REQ-036 During rst, all pulse outputs=0, read_address=write_address=0; sd_cs and sd_mosi follow the init lines.
REQ-037 rst mid-transfer aborts immediately; no done pulse.

Verification
REQ-038 Init handoff: init_done low 10 cycles, init_cs toggling -> sd_cs mirrors init_cs; init_done=1 -> sd_cs=1 for 8 cycles, then IDLE.
REQ-039 Single read: rd_req=1, rd_addr=32'h0000_0100 -> rd_ack, read_address=32'h100, read_start one cycle later.
REQ-040 Single read completion: read_busy high 50 cycles then low -> rd_done once, then 8-cycle gap.
REQ-041 Simultaneous requests: rd_req=wr_req=1 held -> order read, write, read, write; every transfer is followed by an 8-cycle gap.
REQ-042 Timeout: BUSY_TIMEOUT=100, read_busy stuck high -> timeout_err at cycle 100 after RD_BUSY entry; no rd_done; next wr_req served.
REQ-043 Abort: init_done dropped during WR_BUSY -> INIT next cycle; no wr_done or timeout_err; sd_cs follows init_cs.

Source files
------------

// File: rtl/sd_bus_arbiter.sv
// sd_bus_arbiter
//   Shares one SD-card SPI bus between an init engine, a block-read engine and
//   a block-write engine. The init engine owns the bus until init_done; then
//   user read/write requests are accepted one at a time. Simultaneous requests
//   are served round-robin. Every transfer, and the init handoff, is followed
//   by GAP_CYCLES idle cycles with the bus parked high.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   init_done                  init engine finished (level; low forces INIT)
//   init_cs, init_mosi         SPI lines from the init engine
//   rd_req/wr_req              user requests (level)
//   rd_addr/wr_addr            user block addresses
//   rd_ack/wr_ack              request accepted pulses
//   rd_done/wr_done            transfer complete pulses
//   timeout_err                transfer aborted by busy timeout (pulse)
//   read_start/write_start     engine start pulses
//   read_address/write_address addresses latched on the ack cycle
//   read_busy/write_busy       engine busy flags
//   read_cs/read_mosi          SPI lines from the read engine
//   write_cs/write_mosi        SPI lines from the write engine
//   sd_cs/sd_mosi              muxed SPI lines to the card
//   grant                      00 init/none, 01 read, 10 write
module sd_bus_arbiter #(
  parameter int GAP_CYCLES   = 8,
  parameter int BUSY_TIMEOUT = 24'hFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        init_cs,
  input  logic        init_mosi,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] rd_addr,
  input  logic [31:0] wr_addr,
  output logic        rd_ack,
  output logic        wr_ack,
  output logic        rd_done,
  output logic        wr_done,
  output logic        timeout_err,
  output logic        read_start,
  output logic        write_start,
  output logic [31:0] read_address,
  output logic [31:0] write_address,
  input  logic        read_busy,
  input  logic        write_busy,
  input  logic        read_cs,
  input  logic        read_mosi,
  input  logic        write_cs,
  input  logic        write_mosi,
  output logic        sd_cs,
  output logic        sd_mosi,
  output logic [1:0]  grant
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_RD_START, S_RD_BUSY, S_WR_START, S_WR_BUSY, S_GAP
  } state_t;

  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [23:0] TMO_LAST = 24'(BUSY_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic [7:0]  gap_cnt_reg, gap_cnt_next;
  logic [23:0] tmo_cnt_reg, tmo_cnt_next;
  logic        busy_seen_reg, busy_seen_next;
  logic        last_wr_reg, last_wr_next;       // 1: write was granted last
  logic        rd_pend_reg, rd_pend_next;
  logic        wr_pend_reg, wr_pend_next;
  logic [31:0] rd_pend_addr_reg, rd_pend_addr_next;
  logic [31:0] wr_pend_addr_reg, wr_pend_addr_next;
  logic        rd_ack_reg, rd_ack_next;
  logic        wr_ack_reg, wr_ack_next;
  logic        rd_done_reg, rd_done_next;
  logic        wr_done_reg, wr_done_next;
  logic        timeout_err_reg, timeout_err_next;
  logic        read_start_reg, read_start_next;
  logic        write_start_reg, write_start_next;
  logic [31:0] read_address_reg, read_address_next;
  logic [31:0] write_address_reg, write_address_next;

  logic        rd_want, wr_want, is_rd, eng_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= S_INIT;
      gap_cnt_reg       <= '0;
      tmo_cnt_reg       <= '0;
      busy_seen_reg     <= 1'b0;
      last_wr_reg       <= 1'b1;   // makes read the first winner
      rd_pend_reg       <= 1'b0;
      wr_pend_reg       <= 1'b0;
      rd_pend_addr_reg  <= '0;
      wr_pend_addr_reg  <= '0;
      rd_ack_reg        <= 1'b0;
      wr_ack_reg        <= 1'b0;
      rd_done_reg       <= 1'b0;
      wr_done_reg       <= 1'b0;
      timeout_err_reg   <= 1'b0;
      read_start_reg    <= 1'b0;
      write_start_reg   <= 1'b0;
      read_address_reg  <= '0;
      write_address_reg <= '0;
    end else begin
      state_reg         <= state_next;
      gap_cnt_reg       <= gap_cnt_next;
      tmo_cnt_reg       <= tmo_cnt_next;
      busy_seen_reg     <= busy_seen_next;
      last_wr_reg       <= last_wr_next;
      rd_pend_reg       <= rd_pend_next;
      wr_pend_reg       <= wr_pend_next;
      rd_pend_addr_reg  <= rd_pend_addr_next;
      wr_pend_addr_reg  <= wr_pend_addr_next;
      rd_ack_reg        <= rd_ack_next;
      wr_ack_reg        <= wr_ack_next;
      rd_done_reg       <= rd_done_next;
      wr_done_reg       <= wr_done_next;
      timeout_err_reg   <= timeout_err_next;
      read_start_reg    <= read_start_next;
      write_start_reg   <= write_start_next;
      read_address_reg  <= read_address_next;
      write_address_reg <= write_address_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    gap_cnt_next       = gap_cnt_reg;
    tmo_cnt_next       = tmo_cnt_reg;
    busy_seen_next     = busy_seen_reg;
    last_wr_next       = last_wr_reg;
    // A request seen in any state stays pending until it is acked.
    rd_pend_next       = rd_pend_reg | rd_req;
    wr_pend_next       = wr_pend_reg | wr_req;
    rd_pend_addr_next  = rd_req ? rd_addr : rd_pend_addr_reg;
    wr_pend_addr_next  = wr_req ? wr_addr : wr_pend_addr_reg;
    rd_ack_next        = 1'b0;
    wr_ack_next        = 1'b0;
    rd_done_next       = 1'b0;
    wr_done_next       = 1'b0;
    timeout_err_next   = 1'b0;
    read_start_next    = 1'b0;
    write_start_next   = 1'b0;
    read_address_next  = read_address_reg;
    write_address_next = write_address_reg;
    rd_want            = rd_pend_reg | rd_req;
    wr_want            = wr_pend_reg | wr_req;
    is_rd              = (state_reg == S_RD_BUSY);
    eng_busy           = is_rd ? read_busy : write_busy;

    if (!init_done && state_reg != S_INIT) begin
      // Init engine took the bus back: drop whatever was running, silently.
      state_next = S_INIT;
    end else begin
      case (state_reg)
        S_INIT: begin
          if (init_done) begin
            state_next   = S_GAP;
            gap_cnt_next = '0;
          end
        end
        S_IDLE: begin
          if (rd_want && (!wr_want || last_wr_reg)) begin
            state_next        = S_RD_START;
            rd_ack_next       = 1'b1;
            read_address_next = rd_req ? rd_addr : rd_pend_addr_reg;
            rd_pend_next      = 1'b0;
            tmo_cnt_next      = '0;
            busy_seen_next    = 1'b0;
          end else if (wr_want) begin
            state_next         = S_WR_START;
            wr_ack_next        = 1'b1;
            write_address_next = wr_req ? wr_addr : wr_pend_addr_reg;
            wr_pend_next       = 1'b0;
            tmo_cnt_next       = '0;
            busy_seen_next     = 1'b0;
          end
        end
        S_RD_START: begin
          read_start_next = 1'b1;
          state_next      = S_RD_BUSY;
        end
        S_WR_START: begin
          write_start_next = 1'b1;
          state_next       = S_WR_BUSY;
        end
        S_RD_BUSY, S_WR_BUSY: begin
          if (eng_busy) begin
            busy_seen_next = 1'b1;
          end
          // Completion needs a falling edge, i.e. busy was high at least once.
          if (busy_seen_reg && !eng_busy) begin
            rd_done_next = is_rd;
            wr_done_next = !is_rd;
            last_wr_next = !is_rd;
            state_next   = S_GAP;
            gap_cnt_next = '0;
          end else if (tmo_cnt_reg == TMO_LAST) begin
            timeout_err_next = 1'b1;
            last_wr_next     = !is_rd;
            state_next       = S_GAP;
            gap_cnt_next     = '0;
          end else begin
            tmo_cnt_next = tmo_cnt_reg + 24'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt_reg == GAP_LAST) begin
            state_next = S_IDLE;
          end else begin
            gap_cnt_next = gap_cnt_reg + 8'd1;
          end
        end
        default: state_next = S_INIT;
      endcase
    end
  end

  // Bus mux is combinational so the card sees the engine lines with no delay.
  always_comb begin
    sd_cs   = 1'b1;
    sd_mosi = 1'b1;
    grant   = 2'b00;
    case (state_reg)
      S_INIT: begin
        sd_cs   = init_cs;
        sd_mosi = init_mosi;
      end
      S_RD_START, S_RD_BUSY: begin
        sd_cs   = read_cs;
        sd_mosi = read_mosi;
        grant   = 2'b01;
      end
      S_WR_START, S_WR_BUSY: begin
        sd_cs   = write_cs;
        sd_mosi = write_mosi;
        grant   = 2'b10;
      end
      default: ;
    endcase
  end

  assign rd_ack        = rd_ack_reg;
  assign wr_ack        = wr_ack_reg;
  assign rd_done       = rd_done_reg;
  assign wr_done       = wr_done_reg;
  assign timeout_err   = timeout_err_reg;
  assign read_start    = read_start_reg;
  assign write_start   = write_start_reg;
  assign read_address  = read_address_reg;
  assign write_address = write_address_reg;

endmodule

// File: tb/tb_sd_bus_arbiter.sv
// tb_sd_bus_arbiter
//   Directed bench for sd_bus_arbiter with GAP_CYCLES=8, BUSY_TIMEOUT=100.
//   Expected ack/done/timeout events are queued when stimulus is driven and
//   popped by a monitor when the DUT pulses them.
module tb_sd_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_done = 1'b0;
  logic        init_cs = 1'b0;
  logic        init_mosi = 1'b0;
  logic        rd_req = 1'b0;
  logic        wr_req = 1'b0;
  logic [31:0] rd_addr = '0;
  logic [31:0] wr_addr = '0;
  logic        rd_ack, wr_ack, rd_done, wr_done, timeout_err;
  logic        read_start, write_start;
  logic [31:0] read_address, write_address;
  logic        read_busy = 1'b0;
  logic        write_busy = 1'b0;
  logic        read_cs = 1'b0;
  logic        read_mosi = 1'b0;
  logic        write_cs = 1'b0;
  logic        write_mosi = 1'b1;
  logic        sd_cs, sd_mosi;
  logic [1:0]  grant;

  sd_bus_arbiter #(.GAP_CYCLES(8), .BUSY_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .init_cs(init_cs), .init_mosi(init_mosi),
    .rd_req(rd_req), .wr_req(wr_req), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .rd_ack(rd_ack), .wr_ack(wr_ack), .rd_done(rd_done), .wr_done(wr_done),
    .timeout_err(timeout_err), .read_start(read_start), .write_start(write_start),
    .read_address(read_address), .write_address(write_address),
    .read_busy(read_busy), .write_busy(write_busy),
    .read_cs(read_cs), .read_mosi(read_mosi),
    .write_cs(write_cs), .write_mosi(write_mosi),
    .sd_cs(sd_cs), .sd_mosi(sd_mosi), .grant(grant)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] K_RD_ACK = 3'd0, K_WR_ACK = 3'd1, K_RD_DONE = 3'd2,
                         K_WR_DONE = 3'd3, K_TMO = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] addr;
  } ev_t;

  ev_t sb[$];
  int  n_assert = 0;
  int  n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [31:0] addr);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    sb.push_back(e);
  endtask

  task automatic mon_event(input logic [2:0] kind, input logic [31:0] addr);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_event", 32'(kind), 32'hDEAD);
    end else begin
      e = sb.pop_front();
      chk("sb_kind", 32'(kind), 32'(e.kind));
      chk("sb_addr", addr, e.addr);
    end
  endtask

  // Event scoreboard plus per-cycle bus invariants.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_ack)      mon_event(K_RD_ACK, read_address);
      if (wr_ack)      mon_event(K_WR_ACK, write_address);
      if (rd_done)     mon_event(K_RD_DONE, read_address);
      if (wr_done)     mon_event(K_WR_DONE, write_address);
      if (timeout_err) mon_event(K_TMO, 32'h0);
      if (read_start && write_start) chk("both_start", 32'(write_start), 32'h0);
      if (grant == 2'b11)            chk("grant_onehot", 32'(grant), 32'h0);
      if (grant == 2'b01) begin
        chk("mux_rd_cs", 32'(sd_cs), 32'(read_cs));
        chk("mux_rd_mosi", 32'(sd_mosi), 32'(read_mosi));
      end
      if (grant == 2'b10) begin
        chk("mux_wr_cs", 32'(sd_cs), 32'(write_cs));
        chk("mux_wr_mosi", 32'(sd_mosi), 32'(write_mosi));
      end
    end
  end

  // Called on the negedge of a done/timeout pulse (first gap cycle):
  // 7 more gap cycles, one IDLE cycle, then the ack.
  task automatic expect_gap_ack(input bit is_rd);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("gap_sd_cs", 32'(sd_cs), 32'h1);
      chk("gap_grant", 32'(grant), 32'h0);
    end
    @(negedge clk);
    chk(is_rd ? "rd_ack" : "wr_ack", 32'(is_rd ? rd_ack : wr_ack), 32'h1);
    chk("ack_grant", 32'(grant), is_rd ? 32'h1 : 32'h2);
  endtask

  // Called on the ack negedge; returns on the done negedge.
  task automatic run_xfer(input bit is_rd, input int len);
    @(negedge clk);
    chk(is_rd ? "read_start" : "write_start",
        32'(is_rd ? read_start : write_start), 32'h1);
    if (is_rd) read_busy = 1'b1; else write_busy = 1'b1;
    @(negedge clk);
    chk("start_one_cycle", 32'(is_rd ? read_start : write_start), 32'h0);
    repeat (len - 1) @(negedge clk);
    if (is_rd) read_busy = 1'b0; else write_busy = 1'b0;
    @(negedge clk);
    chk(is_rd ? "rd_done" : "wr_done", 32'(is_rd ? rd_done : wr_done), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    init_cs = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_rd_ack", 32'(rd_ack), 32'h0);
    chk("rst_read_start", 32'(read_start), 32'h0);
    chk("rst_timeout", 32'(timeout_err), 32'h0);
    chk("rst_read_address", read_address, 32'h0);
    chk("rst_write_address", write_address, 32'h0);
    chk("rst_sd_cs", 32'(sd_cs), 32'(init_cs));
    rst = 1'b0;

    // Init handoff: sd_cs mirrors a toggling init_cs
    for (int i = 0; i < 10; i++) begin
      init_cs = i[0];
      @(negedge clk);
      chk("init_sd_cs", 32'(sd_cs), 32'(init_cs));
      chk("init_grant", 32'(grant), 32'h0);
    end

    // init_done rises with a read already requested: 1 transfer cycle into
    // GAP, 8 gap cycles, 1 IDLE cycle, then the ack.
    init_cs   = 1'b0;
    init_done = 1'b1;
    rd_req    = 1'b1;
    rd_addr   = 32'h0000_0100;
    push(K_RD_ACK, 32'h100);
    @(negedge clk);
    chk("handoff_sd_cs", 32'(sd_cs), 32'h1);
    expect_gap_ack(1'b1);
    chk("read_address", read_address, 32'h100);
    rd_req = 1'b0;
    push(K_RD_DONE, 32'h100);
    run_xfer(1'b1, 50);

    // Timeout: read engine stuck busy; a write request meanwhile stays pending
    rd_req  = 1'b1;
    rd_addr = 32'h0000_0400;
    push(K_RD_ACK, 32'h400);
    expect_gap_ack(1'b1);
    rd_req = 1'b0;
    @(negedge clk);
    chk("tmo_read_start", 32'(read_start), 32'h1);
    read_busy = 1'b1;
    wr_req    = 1'b1;
    wr_addr   = 32'h0000_0500;
    push(K_TMO, 32'h0);
    push(K_WR_ACK, 32'h500);
    repeat (99) @(negedge clk);
    chk("tmo_not_early", 32'(timeout_err), 32'h0);
    @(negedge clk);
    chk("timeout_err", 32'(timeout_err), 32'h1);
    chk("tmo_no_rd_done", 32'(rd_done), 32'h0);
    read_busy = 1'b0;
    expect_gap_ack(1'b0);
    chk("write_address", write_address, 32'h500);
    wr_req = 1'b0;
    push(K_WR_DONE, 32'h500);
    run_xfer(1'b0, 5);

    // Both requests held: read, write, read, write, then the read that
    // became pending while the last write ran.
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    rd_addr = 32'h0000_0600;
    wr_addr = 32'h0000_0700;
    for (int k = 0; k < 5; k++) begin
      bit is_rd;
      is_rd = (k % 2 == 0);
      push(is_rd ? K_RD_ACK : K_WR_ACK, is_rd ? 32'h600 : 32'h700);
      expect_gap_ack(is_rd);
      if (k == 3) wr_req = 1'b0;
      if (k == 4) rd_req = 1'b0;
      push(is_rd ? K_RD_DONE : K_WR_DONE, is_rd ? 32'h600 : 32'h700);
      run_xfer(is_rd, 3);
    end

    // Abort: init_done drops during WR_BUSY
    wr_req  = 1'b1;
    wr_addr = 32'h0000_0800;
    push(K_WR_ACK, 32'h800);
    expect_gap_ack(1'b0);
    wr_req = 1'b0;
    @(negedge clk);
    chk("abort_write_start", 32'(write_start), 32'h1);
    write_busy = 1'b1;
    repeat (10) @(negedge clk);
    init_done = 1'b0;
    init_cs   = 1'b1;
    @(negedge clk);
    chk("abort_grant", 32'(grant), 32'h0);
    chk("abort_sd_cs", 32'(sd_cs), 32'h1);
    chk("abort_no_wr_done", 32'(wr_done), 32'h0);
    write_busy = 1'b0;
    repeat (120) @(negedge clk);
    chk("abort_still_init", 32'(grant), 32'h0);
    chk("abort_no_timeout", 32'(timeout_err), 32'h0);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
